// File: rtl/multi_issue_queue.sv
// N-push / M-pop in-order issue queue between decode and issue. Circular buffer with wrap-bit
// pointers. Optional stall statistics counter enabled by defining IQ_STATS_EN.
module multi_issue_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PUSH_W = 4,
  parameter int unsigned POP_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flash,
  input  logic [PUSH_W*DATA_W-1:0]      in_data,
  input  logic [$clog2(PUSH_W+1)-1:0]   in_data_number,
  output logic [$clog2(DEPTH+1)-1:0]    iq_size_left,
  output logic [POP_W*DATA_W-1:0]       out_data,
  output logic [$clog2(POP_W+1)-1:0]    iq_size,
  input  logic [$clog2(POP_W+1)-1:0]    out_data_number,
  output logic                          overflow_err
`ifdef IQ_STATS_EN
  ,
  output logic [31:0]                   full_stall_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PN_W  = $clog2(PUSH_W + 1);
  localparam int unsigned PP_W  = $clog2(POP_W + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  count;
  logic              overflow_q, overflow_d;
  logic              push_ok;
  logic [PP_W-1:0]   pop_n;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_idx [PUSH_W];
  logic [PUSH_W-1:0] wr_en;
  logic [IDX_W-1:0]  rd_idx [POP_W];

  // Status derived from registered pointers only; same-cycle pops are not credited.
  always_comb begin
    count        = tail_q - head_q;
    iq_size_left = CNT_W'(DEPTH) - CNT_W'(count);
    iq_size      = (count >= PTR_W'(POP_W)) ? PP_W'(POP_W) : PP_W'(count);
    push_ok      = CNT_W'(in_data_number) <= iq_size_left;
    pop_n        = (out_data_number > iq_size) ? iq_size : out_data_number;
    overflow_err = overflow_q;
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      wr_idx[i] = IDX_W'(tail_q + PTR_W'(i));
      wr_en[i]  = !flash && push_ok && (PN_W'(i) < in_data_number);
    end
  end

  // Zero-latency peek of the head entries; slots beyond count read as zero.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      rd_idx[i] = IDX_W'(head_q + PTR_W'(i));
      if (PTR_W'(i) < count) begin
        out_data[i*DATA_W +: DATA_W] = mem_q[rd_idx[i]];
      end
    end
  end

  // Flush overrides push and pop but keeps the sticky overflow flag.
  always_comb begin
    head_d     = head_q + PTR_W'(pop_n);
    tail_d     = tail_q + (push_ok ? PTR_W'(in_data_number) : '0);
    overflow_d = overflow_q | (!flash && !push_ok);
    if (flash) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: unread slots are masked at the output.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef IQ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flash && !push_ok && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign full_stall_cnt = stall_cnt_q;
`endif

  a_push_legal : assert property (@(posedge clk) disable iff (!rst_n)
    in_data_number <= PN_W'(PUSH_W));
  a_pop_legal : assert property (@(posedge clk) disable iff (!rst_n)
    out_data_number <= PP_W'(POP_W));

endmodule
